// File: rtl/uart_echo_responder.sv
// uart_echo_responder: byte-level loopback for the far end of a UART link.
// Captures bytes from a uart_top receiver, buffers them in a small ring FIFO
// (optionally XOR-masked) and retransmits them in arrival order through the
// same uart_top transmitter.
module uart_echo_responder #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] ECHO_XOR     = 8'h00,
    parameter int         BUSY_TIMEOUT = 15
) (
    input  logic                        clk_50mhz,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        rx_data_ready,
    input  logic [7:0]                  rx_byte,
    output logic                        rx_clear_ready,
    input  logic                        tx_active,
    output logic [7:0]                  tx_byte,
    output logic                        write_enable,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  overflow_count,
    output logic [15:0]                 echo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT_DONE} tx_state_t;

    rx_state_t       rx_st_q, rx_st_d;
    tx_state_t       tx_st_q, tx_st_d;
    logic            rcr_q, rcr_d;
    logic [7:0]      ovf_q, ovf_d;
    logic            we_q, we_d;
    logic [7:0]      txb_q, txb_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [15:0]     echo_q, echo_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];

    logic            push, pop;
    logic            full, empty;

    // Full/empty come straight from the registered level so neither FSM
    // sees a combinational path through the other's push/pop decision.
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);

    // RX FSM: capture one byte per rx_data_ready assertion, then acknowledge
    // and wait for the level to drop so a held byte is not taken twice.
    always_comb begin
        rx_st_d = rx_st_q;
        rcr_d   = 1'b0;
        ovf_d   = ovf_q;
        push    = 1'b0;
        case (rx_st_q)
            R_IDLE: begin
                if (rx_data_ready) begin
                    rx_st_d = R_ACK;
                    if (enable) begin
                        if (!full) begin
                            push = 1'b1;
                        end else if (ovf_q != 8'hFF) begin
                            ovf_d = ovf_q + 8'd1;
                        end
                    end
                end
            end
            R_ACK: begin
                rcr_d   = 1'b1;
                rx_st_d = R_WAIT;
            end
            R_WAIT: begin
                if (!rx_data_ready) rx_st_d = R_IDLE;
            end
            default: rx_st_d = R_IDLE;
        endcase
    end

    // TX FSM: hand the FIFO head to the transmitter, then track tx_active
    // through one busy period; give up on the byte if busy never shows.
    always_comb begin
        tx_st_d = tx_st_q;
        we_d    = 1'b0;
        txb_d   = txb_q;
        tmo_d   = tmo_q;
        echo_d  = echo_q;
        pop     = 1'b0;
        case (tx_st_q)
            T_IDLE: begin
                if (!empty && !tx_active) begin
                    txb_d   = mem_q[rd_ptr_q];
                    we_d    = 1'b1;
                    pop     = 1'b1;
                    tmo_d   = '0;
                    tx_st_d = T_START;
                end
            end
            T_START: begin
                if (tx_active) begin
                    tx_st_d = T_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    tx_st_d = T_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            T_WAIT_DONE: begin
                if (!tx_active) begin
                    echo_d  = echo_q + 16'd1;
                    tx_st_d = T_IDLE;
                end
            end
            default: tx_st_d = T_IDLE;
        endcase
    end

    // FIFO bookkeeping: pointers wrap naturally (depth is a power of two);
    // a simultaneous push and pop leaves the level unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = rx_byte ^ ECHO_XOR;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            rx_st_q  <= R_IDLE;
            tx_st_q  <= T_IDLE;
            rcr_q    <= 1'b0;
            ovf_q    <= '0;
            we_q     <= 1'b0;
            txb_q    <= '0;
            tmo_q    <= '0;
            echo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rx_st_q  <= rx_st_d;
            tx_st_q  <= tx_st_d;
            rcr_q    <= rcr_d;
            ovf_q    <= ovf_d;
            we_q     <= we_d;
            txb_q    <= txb_d;
            tmo_q    <= tmo_d;
            echo_q   <= echo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Buffer storage needs no reset; an empty level hides stale contents.
    always_ff @(posedge clk_50mhz) begin
        mem_q <= mem_d;
    end

    assign rx_clear_ready = rcr_q;
    assign write_enable   = we_q;
    assign tx_byte        = txb_q;
    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;
    assign echo_count     = echo_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Bench for uart_echo_responder: a uart_top-like byte model drives the RX
// side, a busy-period model answers write_enable, and a queue of expected
// echoes checks every transmit request.
module tb_uart_echo_responder;

    localparam int         DEPTH = 4;
    localparam logic [7:0] XMASK = 8'hFF;

    logic        clk_50mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        rx_data_ready = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_active = 1'b0;
    logic        rx_clear_ready;
    logic        write_enable;
    logic [7:0]  tx_byte;
    logic [2:0]  fifo_level;
    logic [7:0]  overflow_count;
    logic [15:0] echo_count;

    uart_echo_responder #(
        .FIFO_DEPTH  (DEPTH),
        .ECHO_XOR    (XMASK),
        .BUSY_TIMEOUT(15)
    ) dut (
        .clk_50mhz     (clk_50mhz),
        .rst_n         (rst_n),
        .enable        (enable),
        .rx_data_ready (rx_data_ready),
        .rx_byte       (rx_byte),
        .rx_clear_ready(rx_clear_ready),
        .tx_active     (tx_active),
        .tx_byte       (tx_byte),
        .write_enable  (write_enable),
        .fifo_level    (fifo_level),
        .overflow_count(overflow_count),
        .echo_count    (echo_count)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [7:0] exp_q [$];
    int exp_ovf = 0;
    int exp_echo = 0;

    // transmitter model controls
    bit hold_busy = 1'b0;
    bit no_rise = 1'b0;
    int busy_len = 10;
    int busy_left = 0;

    // observation
    int cyc = 0;
    int we_cnt = 0;
    int rcr_cnt = 0;
    int we_last = -100;
    int we_gap = 0;
    logic prev_we = 1'b0;
    logic prev_rcr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A delivered byte is echoed if enabled and there is room, else counted
    // as an overflow (enabled) or silently discarded (disabled).
    task automatic model_rx(input logic [7:0] b);
        if (enable) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b ^ XMASK);
            else if (exp_ovf < 255) exp_ovf++;
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (rx_clear_ready !== 1'b1 && n < 20) begin
            @(negedge clk_50mhz); #1;
            n++;
        end
        chk("rcr_seen", n < 20, 1);
        rx_data_ready = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, output int n);
        @(negedge clk_50mhz); #1;
        rx_byte = b;
        rx_data_ready = 1'b1;
        model_rx(b);
        wait_ack(n);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_left != 0 || tx_active) && n < 2000) begin
            @(negedge clk_50mhz); #1;
            n++;
        end
        chk({tag, "_drain"}, n < 2000, 1);
        repeat (3) @(negedge clk_50mhz);
        #1;
    endtask

    // Transmitter model and transmit-request monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk_50mhz);
        cyc++;
        if (write_enable === 1'b1) begin
            chk("we_single_cycle", prev_we, 0);
            we_cnt++;
            we_gap = cyc - we_last;
            we_last = cyc;
            chk("we_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("tx_byte", tx_byte, exp_q.pop_front());
            if (!no_rise) busy_left = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) exp_echo++;
        end
        if (rx_clear_ready === 1'b1) begin
            chk("rcr_single_cycle", prev_rcr, 0);
            rcr_cnt++;
        end
        prev_we = write_enable;
        prev_rcr = rx_clear_ready;
        tx_active = hold_busy || (busy_left > 0);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0, e0, o0;

        // reset held with a byte pending
        rx_byte = 8'h11;
        rx_data_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        #1;
        chk("rst_rcr", rx_clear_ready, 0);
        chk("rst_we", write_enable, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow_count, 0);
        chk("rst_echo", echo_count, 0);
        chk("rst_no_ack", rcr_cnt, 0);
        model_rx(8'h11);
        rst_n = 1'b1;
        wait_ack(n);
        drain("rst");
        chk("rst_ack_once", rcr_cnt, 1);
        chk("rst_echo_after", echo_count, exp_echo);

        // single byte: ack and transmit request land in the same cycle
        send(8'h5A, n);
        chk("single_ack_latency", n, 2);
        chk("single_we_with_ack", write_enable, 1);
        chk("single_tx_byte", tx_byte, 8'h5A ^ XMASK);
        drain("single");
        chk("single_echo", echo_count, exp_echo);
        chk("single_echo_abs", echo_count, 2);

        // burst into a busy transmitter, then release
        hold_busy = 1'b1;
        repeat (2) @(negedge clk_50mhz);
        w0 = we_cnt;
        for (int i = 0; i < 6; i++) send(8'(i), n);
        @(negedge clk_50mhz); #1;
        chk("burst_level", fifo_level, DEPTH);
        chk("burst_ovf", overflow_count, exp_ovf);
        chk("burst_ovf_abs", overflow_count, 2);
        chk("burst_no_we", we_cnt, w0);
        hold_busy = 1'b0;
        drain("burst");
        chk("burst_echo", echo_count, exp_echo);
        chk("burst_level_empty", fifo_level, 0);

        // transmitter never goes busy: each request times out, next still issued
        hold_busy = 1'b1;
        repeat (2) @(negedge clk_50mhz);
        send(8'h21, n);
        send(8'h22, n);
        w0 = we_cnt;
        e0 = exp_echo;
        #1;
        no_rise = 1'b1;
        hold_busy = 1'b0;
        repeat (45) @(negedge clk_50mhz);
        #1;
        chk("tmo_requests", we_cnt - w0, 2);
        chk("tmo_gap", we_gap, 16);
        chk("tmo_echo", echo_count, e0);
        chk("tmo_level", fifo_level, 0);
        no_rise = 1'b0;

        // disabled: acknowledged and discarded
        enable = 1'b0;
        o0 = exp_ovf;
        w0 = we_cnt;
        send(8'hC3, n);
        chk("dis_ack_latency", n, 2);
        repeat (20) @(negedge clk_50mhz);
        #1;
        chk("dis_level", fifo_level, 0);
        chk("dis_ovf", overflow_count, o0);
        chk("dis_no_we", we_cnt, w0);
        enable = 1'b1;

        // random bytes, random enable, random busy lengths, spaced to drain
        for (int i = 0; i < 40; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            busy_len = $urandom_range(1, 10);
            send(8'($urandom), n);
            repeat ($urandom_range(14, 20)) @(negedge clk_50mhz);
        end
        enable = 1'b1;
        drain("rand");
        chk("rand_echo", echo_count, exp_echo);
        chk("rand_ovf", overflow_count, exp_ovf);
        chk("rand_level", fifo_level, 0);

        // full byte sweep at a pace the echo path can sustain
        busy_len = 3;
        e0 = exp_echo;
        o0 = exp_ovf;
        for (int i = 0; i < 256; i++) begin
            send(8'(i), n);
            repeat (6) @(negedge clk_50mhz);
        end
        drain("sweep");
        chk("sweep_echo", echo_count, 16'(e0 + 256));
        chk("sweep_ovf", overflow_count, o0);
        chk("final_echo", echo_count, 16'(exp_echo));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
